sw_to_fw_op_decoder: RTL
========================

// Module: sw_to_fw_op_decoder
// PURPOSE
// - Upstream stage of every FW IP block: takes the SW command word sw_write32_0 and decodes it into device-select levels and op-code pulses.
// - Command word: [31:28] dev_id, [27:24] op_code, [23:0] payload.
// - Also returns the selected FW IP's read data/status to SW through a registered N:1 mux.
// PARAMETERS
// - NUM_FW          15  FW IP slots; dev_id 1..NUM_FW maps to slot dev_id-1.
// - HOLDOFF_CYCLES  4   idle cycles enforced after each issued command (0 allowed).
// PORTS
// - fw_clk            in   1          FW clock, mapped to S_AXI_ACLK.
// - fw_rst_n          in   1          FW reset, active low, synchronous; mapped to S_AXI_ARESETN.
// - sw_write32_0      in   32         SW command word.
// - sw_write_strobe   in   1          1-cycle pulse: sw_write32_0 newly written.
// - fw_dev_id_enable  out  NUM_FW     one-hot level, slot of last issued command.
// - fw_op_code_pulse  out  13         one-hot 1-cycle op pulse, indexed by the op_code_e package type.
// - sw_write24_0      out  24         payload latched at accept, held until next accept.
// - fw_read_data32_i  in   NUM_FW*32  packed FW read data, slot 0 at LSBs.
// - fw_read_stat32_i  in   NUM_FW*32  packed FW read status.
// - sw_read_data32    out  32         registered read data to SW.
// - sw_read_status32  out  32         registered read status to SW.
// - busy              out  1          high in ISSUE/HOLDOFF.
// - cmd_error         out  1          sticky: dropped or illegal command seen.
// BEHAVIOUR
// - Reset values: every output 0; FSM = IDLE; counters 0; rd_sel = 0.
// - Synchronous reset wins over everything at the edge. A pulse in flight is truncated.
// - FSM states: IDLE, ISSUE, HOLDOFF.
//   - IDLE + strobe + legal command: capture the word -> ISSUE.
//   - ISSUE lasts 1 cycle. In it:
//     - fw_op_code_pulse[op] = 1.
//     - fw_dev_id_enable and sw_write24_0 update that same cycle (registered from the capture).
//     - Then -> HOLDOFF if HOLDOFF_CYCLES > 0, else -> IDLE.
//   - HOLDOFF counts HOLDOFF_CYCLES cycles, then -> IDLE.
//   - Latency strobe -> pulse = 1 cycle; accept-to-accept minimum = 2 + HOLDOFF_CYCLES.
// - Legal command: dev_id in 1..NUM_FW and op_code in 0x0..0xC.
//   - 0 w_reset; 1/2 w/r_cfg_static_0; 3/4 w/r_cfg_static_1; 5/6 w/r_cfg_array_0; 7/8 w/r_cfg_array_1.
//   - 9/A r_data_array_0/1; B w_status_clear; C w_execute.
// - Illegal command (dev_id 0, dev_id > NUM_FW, op_code 0xD..0xF):
//   - Not issued; outputs unchanged.
//   - drop_cnt++ (8-bit, saturating at 0xFF); cmd_error set.
// - Strobe while busy: dropped, same drop_cnt/cmd_error handling. The captured word is unaffected.
// - Strobe coincident with the HOLDOFF->IDLE transition cycle counts as busy (dropped).
// - Accepted w_status_clear (op B) clears cmd_error and drop_cnt in the ISSUE cycle; the pulse is still forwarded.
// - Every legal accept: acc_cnt++ (16-bit, wraps 0xFFFF -> 0).
// - Read path:
//   - rd_sel loads on every legal accept, read or write op.
//   - sw_read_data32/status32 = fw_*_i[rd_sel] registered, continuous, 1-cycle latency.
// CONFIGURATION
// - Macro SW_TO_FW_DIAG_EN.
// - Defined:
//   - A legal-format command with dev_id 0 and op 0x2 is accepted (no pulse, dev enable cleared).
//   - rd_sel switches to DIAG.
//   - sw_read_data32 = {8'h5A, drop_cnt, acc_cnt}; sw_read_status32 = {31'b0, cmd_error}.
//   - Counts as legal for acc_cnt.
// - Undefined: dev_id 0 always illegal; no diagnostic word; counters are internal only.
// STRUCTURE
// - Package sw_to_fw_pkg holds:
//   - Field LSB/MSB constants (DEV_ID, OP_CODE, PAYLOAD).
//   - op_code_e enum (13 values) and NUM_OPS = 13.
//   - fsm_state_e.
//   - DIAG_SIG = 8'h5A.
// - Sub-module sw_to_fw_rd_mux: registered NUM_FW:1 32-bit mux with sync reset, instantiated twice (data, status).
// TESTING
// - Reset, then strobe 0x3_C_00ABCD:
//   - Next cycle: fw_op_code_pulse[C] for exactly 1 cycle; fw_dev_id_enable = 15'h0004; sw_write24_0 = 0x00ABCD.
//   - busy high for 1 + 4 cycles.
// - Two strobes 2 cycles apart (second hits HOLDOFF):
//   - Second produces no pulse; drop_cnt = 1; cmd_error = 1.
//   - A later legal 0x3_B_000000 clears cmd_error.
// - Strobe 0x1_E_000000 and 0x0_1_000000 in IDLE: no pulses, enables unchanged, drop_cnt = 2.
// - Drive slot 6 read data 0xDEADBEEF; strobe 0x7_9_000000: sw_read_data32 = 0xDEADBEEF from 2 cycles after the strobe.
// - Assert fw_rst_n = 0 during ISSUE: next edge all outputs 0, FSM IDLE; the next strobe is accepted normally.
// - With SW_TO_FW_DIAG_EN, after 3 accepts and 1 drop, strobe 0x0_2_000000: sw_read_data32 = 0x5A010004.

Source files
------------

// File: rtl/sw_to_fw_pkg.sv
// Shared field positions, op-code/state encodings and diagnostic constants for the SW-to-FW command decoder.
package sw_to_fw_pkg;

  localparam int DEV_ID_MSB  = 31;
  localparam int DEV_ID_LSB  = 28;
  localparam int OP_CODE_MSB = 27;
  localparam int OP_CODE_LSB = 24;
  localparam int PAYLOAD_MSB = 23;
  localparam int PAYLOAD_LSB = 0;

  localparam int NUM_OPS = 13;

  typedef enum logic [3:0] {
    OP_W_RESET         = 4'h0,
    OP_W_CFG_STATIC_0  = 4'h1,
    OP_R_CFG_STATIC_0  = 4'h2,
    OP_W_CFG_STATIC_1  = 4'h3,
    OP_R_CFG_STATIC_1  = 4'h4,
    OP_W_CFG_ARRAY_0   = 4'h5,
    OP_R_CFG_ARRAY_0   = 4'h6,
    OP_W_CFG_ARRAY_1   = 4'h7,
    OP_R_CFG_ARRAY_1   = 4'h8,
    OP_R_DATA_ARRAY_0  = 4'h9,
    OP_R_DATA_ARRAY_1  = 4'hA,
    OP_W_STATUS_CLEAR  = 4'hB,
    OP_W_EXECUTE       = 4'hC
  } op_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } fsm_state_e;

  localparam logic [7:0] DIAG_SIG = 8'h5A;

endpackage

// File: rtl/sw_to_fw_op_decoder_if.sv
// SW command / FW select / read-back bundle between the SW register block (master) and the decoder (slave).
interface sw_to_fw_op_decoder_if #(
  parameter int NUM_FW = 15
) ();
  import sw_to_fw_pkg::*;

  logic [31:0]          sw_write32_0;
  logic                 sw_write_strobe;
  logic [NUM_FW-1:0]    fw_dev_id_enable;
  logic [NUM_OPS-1:0]   fw_op_code_pulse;
  logic [23:0]          sw_write24_0;
  logic [NUM_FW*32-1:0] fw_read_data32_i;
  logic [NUM_FW*32-1:0] fw_read_stat32_i;
  logic [31:0]          sw_read_data32;
  logic [31:0]          sw_read_status32;
  logic                 busy;
  logic                 cmd_error;

  modport master (
    output sw_write32_0, sw_write_strobe, fw_read_data32_i, fw_read_stat32_i,
    input  fw_dev_id_enable, fw_op_code_pulse, sw_write24_0,
           sw_read_data32, sw_read_status32, busy, cmd_error
  );

  modport slave (
    input  sw_write32_0, sw_write_strobe, fw_read_data32_i, fw_read_stat32_i,
    output fw_dev_id_enable, fw_op_code_pulse, sw_write24_0,
           sw_read_data32, sw_read_status32, busy, cmd_error
  );

endinterface

// File: rtl/sw_to_fw_rd_mux.sv
// Registered N:1 word mux with synchronous active-low reset; one cycle from sel/din to dout.
module sw_to_fw_rd_mux #(
  parameter int N     = 15,
  parameter int W     = 32,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   din,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     dout
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (int'(sel) < N) begin
      dout <= din[sel*W +: W];
    end else begin
      dout <= '0;
    end
  end

endmodule

// File: rtl/sw_to_fw_op_decoder.sv
// Decodes SW command words into FW device-select levels and one-cycle op pulses, with registered read-back.
// Optional diagnostic read-back (dev_id 0, op 0x2) is enabled by defining SW_TO_FW_DIAG_EN.
module sw_to_fw_op_decoder
  import sw_to_fw_pkg::*;
#(
  parameter int NUM_FW         = 15,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                  fw_clk,
  input  logic                  fw_rst_n,
  sw_to_fw_op_decoder_if.slave  bus
);

  localparam int SEL_W = (NUM_FW > 1) ? $clog2(NUM_FW) : 1;
  localparam int HC_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  fsm_state_e         state, state_nx;
  logic [HC_W-1:0]    hold_cnt;
  logic [3:0]         dev_id, op_code;
  logic               diag_cmd, legal, accept, drop;
  logic [7:0]         drop_cnt;
  logic [15:0]        acc_cnt;
  logic [NUM_FW-1:0]  dev_en;
  logic [NUM_OPS-1:0] op_pulse;
  logic [23:0]        payload;
  logic               cmd_err;
  logic [SEL_W-1:0]   rd_sel;
  logic [31:0]        mux_data, mux_stat;

  always_comb begin
    dev_id   = bus.sw_write32_0[DEV_ID_MSB:DEV_ID_LSB];
    op_code  = bus.sw_write32_0[OP_CODE_MSB:OP_CODE_LSB];
    diag_cmd = 1'b0;
`ifdef SW_TO_FW_DIAG_EN
    diag_cmd = (dev_id == 4'd0) && (op_code == OP_R_CFG_STATIC_0);
`endif
    legal  = ((dev_id != 4'd0) && (int'(dev_id) <= NUM_FW) && (int'(op_code) < NUM_OPS))
             || diag_cmd;
    // Anything strobed outside IDLE (including the HOLDOFF exit cycle) is a drop.
    accept = (state == ST_IDLE) && bus.sw_write_strobe && legal;
    drop   = bus.sw_write_strobe && !accept;

    state_nx = state;
    case (state)
      ST_IDLE:    if (accept) state_nx = ST_ISSUE;
      ST_ISSUE:   state_nx = (HOLDOFF_CYCLES > 0) ? ST_HOLDOFF : ST_IDLE;
      ST_HOLDOFF: if (hold_cnt == HC_W'(HOLDOFF_CYCLES - 1)) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge fw_clk) begin
    if (!fw_rst_n) state <= ST_IDLE;
    else           state <= state_nx;
  end

`ifdef SW_TO_FW_DIAG_EN
  logic        diag_sel, diag_rd_q, diag_err_q;
  logic [31:0] diag_data_q;
`endif

  always_ff @(posedge fw_clk) begin
    if (!fw_rst_n) begin
      hold_cnt <= '0;
      op_pulse <= '0;
      dev_en   <= '0;
      payload  <= '0;
      rd_sel   <= '0;
      acc_cnt  <= '0;
      drop_cnt <= '0;
      cmd_err  <= 1'b0;
`ifdef SW_TO_FW_DIAG_EN
      diag_sel <= 1'b0;
`endif
    end else begin
      hold_cnt <= (state == ST_HOLDOFF) ? hold_cnt + HC_W'(1) : '0;
      op_pulse <= '0;
      if (accept) begin
        payload <= bus.sw_write32_0[PAYLOAD_MSB:PAYLOAD_LSB];
        acc_cnt <= acc_cnt + 16'd1;
`ifdef SW_TO_FW_DIAG_EN
        diag_sel <= diag_cmd;
`endif
        if (diag_cmd) begin
          dev_en <= '0;
          rd_sel <= '0;
        end else begin
          dev_en   <= NUM_FW'(1) << (dev_id - 4'd1);
          op_pulse <= NUM_OPS'(1) << op_code;
          rd_sel   <= SEL_W'(dev_id - 4'd1);
        end
        if (op_code == OP_W_STATUS_CLEAR) begin
          cmd_err  <= 1'b0;
          drop_cnt <= '0;
        end
      end else if (drop) begin
        cmd_err <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  sw_to_fw_rd_mux #(.N(NUM_FW), .W(32), .SEL_W(SEL_W)) u_rd_data (
    .clk(fw_clk), .rst_n(fw_rst_n), .din(bus.fw_read_data32_i), .sel(rd_sel), .dout(mux_data)
  );

  sw_to_fw_rd_mux #(.N(NUM_FW), .W(32), .SEL_W(SEL_W)) u_rd_stat (
    .clk(fw_clk), .rst_n(fw_rst_n), .din(bus.fw_read_stat32_i), .sel(rd_sel), .dout(mux_stat)
  );

`ifdef SW_TO_FW_DIAG_EN
  // Diagnostic word is registered alongside the slot mux so read latency stays one cycle.
  always_ff @(posedge fw_clk) begin
    if (!fw_rst_n) begin
      diag_rd_q   <= 1'b0;
      diag_data_q <= '0;
      diag_err_q  <= 1'b0;
    end else begin
      diag_rd_q   <= diag_sel;
      diag_data_q <= {DIAG_SIG, drop_cnt, acc_cnt};
      diag_err_q  <= cmd_err;
    end
  end
  assign bus.sw_read_data32   = diag_rd_q ? diag_data_q : mux_data;
  assign bus.sw_read_status32 = diag_rd_q ? {31'b0, diag_err_q} : mux_stat;
`else
  assign bus.sw_read_data32   = mux_data;
  assign bus.sw_read_status32 = mux_stat;
`endif

  assign bus.fw_dev_id_enable = dev_en;
  assign bus.fw_op_code_pulse = op_pulse;
  assign bus.sw_write24_0     = payload;
  assign bus.busy             = (state != ST_IDLE);
  assign bus.cmd_error        = cmd_err;

endmodule
